space_wire_stat_dump: RTL

Reads the SpaceWire link statistics counters and status monitor bits, then streams them to the host side as a framed byte stream. It snapshots all counters atomically on request and serialises a selectable subset over a valid/ready byte interface. Optionally, it issues a clear pulse back to the statistics block once the frame completes. It sits between the statistics counter block (same i_clk domain) and the host register/UART readout path.

---
 rtl/space_wire_stat_dump.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/space_wire_stat_dump.sv
// SpaceWire statistics dump: snapshots the link counters and the sticky monitor bits on request,
// then streams a framed byte sequence (header, selected counters MSB first, trailer) over valid/ready.
module space_wire_stat_dump #(
  parameter int NUM_CNT = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [255:0] i_stat_cnt,
  input  logic [6:0]   i_char_mon,
  input  logic         i_dump_req,
  input  logic [7:0]   i_dump_mask,
  input  logic         i_clear_after,
  output logic         o_busy,
  output logic [7:0]   o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_last,
  output logic         o_stat_clear,
  output logic [6:0]   o_char_sticky
);

  localparam logic [8:0] CNT_ONES_C = (9'd1 << NUM_CNT) - 9'd1;
  localparam logic [7:0] CNT_MASK_C = CNT_ONES_C[7:0];

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CNT  = 3'd2,
    TRL  = 3'd3,
    CLR  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] snap_r [8];
  logic [7:0]  mask_r;
  logic        clr_r;
  logic [6:0]  mon_r;
  logic [6:0]  sticky_r;
  logic [2:0]  idx_r, idx_s;
  logic [1:0]  byte_r, byte_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s;
  logic        last_r, last_s;
  logic        clear_r, clear_s;
  logic        busy_r, busy_s;
  logic        accept_s;
  logic        xfer_s;
  logic [3:0]  nxt_s;

  // Lowest set bit of m at or above index 'from'; bit 3 of the result flags that one exists.
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) begin
        r = {1'b1, 3'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Byte b of a counter word, most significant byte first.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] b);
    logic [7:0] r;
    case (b)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      2'd3:    r = w[7:0];
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  assign accept_s = (state_r == IDLE) && i_dump_req;
  assign xfer_s   = valid_r && i_ready;

  // Next-state and next-output computation; outputs hold while the sink stalls.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    byte_s  = byte_r;
    data_s  = data_r;
    valid_s = valid_r;
    last_s  = last_r;
    clear_s = 1'b0;
    nxt_s   = 4'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = HDR;
          data_s  = i_dump_mask & CNT_MASK_C;
          valid_s = 1'b1;
          last_s  = 1'b0;
        end else begin
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      end
      HDR: begin
        if (xfer_s) begin
          nxt_s = next_set(mask_r, 4'd0);
          if (nxt_s[3]) begin
            state_s = CNT;
            idx_s   = nxt_s[2:0];
            byte_s  = 2'd0;
            data_s  = snap_r[nxt_s[2:0]][31:24];
          end else begin
            state_s = TRL;
            data_s  = {1'b0, mon_r};
            last_s  = 1'b1;
          end
        end else begin
          state_s = HDR;
        end
      end
      CNT: begin
        if (xfer_s) begin
          if (byte_r == 2'd3) begin
            nxt_s = next_set(mask_r, {1'b0, idx_r} + 4'd1);
            if (nxt_s[3]) begin
              idx_s  = nxt_s[2:0];
              byte_s = 2'd0;
              data_s = snap_r[nxt_s[2:0]][31:24];
            end else begin
              state_s = TRL;
              data_s  = {1'b0, mon_r};
              last_s  = 1'b1;
            end
          end else begin
            byte_s = byte_r + 2'd1;
            data_s = byte_of(snap_r[idx_r], byte_r + 2'd1);
          end
        end else begin
          state_s = CNT;
        end
      end
      TRL: begin
        if (xfer_s) begin
          valid_s = 1'b0;
          last_s  = 1'b0;
          data_s  = 8'd0;
          if (clr_r) begin
            state_s = CLR;
            clear_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = TRL;
        end
      end
      CLR: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state, frame position and registered stream outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      byte_r  <= 2'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      clear_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      byte_r  <= byte_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      clear_r <= clear_s;
      busy_r  <= busy_s;
    end
  end

  // Atomic snapshot on accept; sticky monitor bits hand over to mon_r without losing a pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < 8; k++) begin
        snap_r[k] <= 32'd0;
      end
      mask_r   <= 8'd0;
      clr_r    <= 1'b0;
      mon_r    <= 7'd0;
      sticky_r <= 7'd0;
    end else if (accept_s) begin
      for (int k = 0; k < 8; k++) begin
        snap_r[k] <= i_stat_cnt[32*k +: 32];
      end
      mask_r   <= i_dump_mask & CNT_MASK_C;
      clr_r    <= i_clear_after;
      mon_r    <= sticky_r | i_char_mon;
      sticky_r <= 7'd0;
    end else begin
      sticky_r <= sticky_r | i_char_mon;
    end
  end

  assign o_busy        = busy_r;
  assign o_data        = data_r;
  assign o_valid       = valid_r;
  assign o_last        = last_r;
  assign o_stat_clear  = clear_r;
  assign o_char_sticky = sticky_r;

endmodule
